// File: rtl/pong_vga_renderer.sv
// Pong display back end: VGA raster timing, per-frame position snapshot, per-pixel colour.
// Define PONG_WALL_DRAW_EN to draw the grey border wall.
module pong_vga_renderer #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned PADDLE1_L    = 39,
  parameter int unsigned PADDLE1_R    = 49,
  parameter int unsigned PADDLE2_L    = 590,
  parameter int unsigned PADDLE2_R    = 600,
  parameter int unsigned PADDLE_LEN   = 50,
  parameter int unsigned BALL_SIZE    = 10,
`ifdef PONG_WALL_DRAW_EN
  parameter int unsigned WALL_W       = 10,
`endif
  parameter int unsigned FLASH_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle1_y,
  input  logic [9:0] paddle2_y,
  input  logic       miss1,
  input  logic       miss2,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_S = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_E = H_SYNC_S + H_SYNC;
  localparam int unsigned V_SYNC_S = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_E = V_SYNC_S + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FL_W     = $clog2(FLASH_FRAMES + 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [9:0]       sbx_q, sbx_d, sby_q, sby_d, sp1_q, sp1_d, sp2_q, sp2_d;
  logic [FL_W-1:0]  flash_q, flash_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             video_on_q, video_on_d, frame_tick_q, frame_tick_d;
  logic [11:0]      rgb_q, rgb_d, pix_rgb;
  logic [9:0]       pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic             pix_tick, h_wrap, frame_evt, active;
  logic             ball_hit, pad1_hit, pad2_hit;
  logic [10:0]      h_e, v_e;
`ifdef PONG_WALL_DRAW_EN
  logic             wall_hit;
`endif

  // Pixel divider and raster counters
  always_comb begin
    pix_tick  = (div_q == DIV_W'(CLK_DIV - 1));
    h_wrap    = (h_q == 10'(H_TOTAL - 1));
    frame_evt = pix_tick && h_wrap && (v_q == 10'(V_ACTIVE - 1));
    div_d     = pix_tick ? '0 : div_q + DIV_W'(1);
    h_d       = h_q;
    v_d       = v_q;
    if (pix_tick) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
      if (h_wrap) v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
    end
  end

  // Snapshot at vblank start; a miss reload beats the per-frame decrement
  always_comb begin
    sbx_d   = sbx_q;
    sby_d   = sby_q;
    sp1_d   = sp1_q;
    sp2_d   = sp2_q;
    flash_d = flash_q;
    if (frame_evt) begin
      sbx_d = ball_x;
      sby_d = ball_y;
      sp1_d = paddle1_y;
      sp2_d = paddle2_y;
    end
    if (miss1 || miss2)                 flash_d = FL_W'(FLASH_FRAMES);
    else if (frame_evt && flash_q != '0) flash_d = flash_q - FL_W'(1);
  end

  // Hit tests are 11 bits wide so objects near 1023 never wrap onto row/column 0
  always_comb begin
    h_e      = {1'b0, h_q};
    v_e      = {1'b0, v_q};
    active   = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    ball_hit = (h_e >= {1'b0, sbx_q}) && (h_e < {1'b0, sbx_q} + 11'(BALL_SIZE)) &&
               (v_e >= {1'b0, sby_q}) && (v_e < {1'b0, sby_q} + 11'(BALL_SIZE));
    pad1_hit = (h_q >= 10'(PADDLE1_L)) && (h_q <= 10'(PADDLE1_R)) &&
               (v_e >= {1'b0, sp1_q}) && (v_e < {1'b0, sp1_q} + 11'(PADDLE_LEN));
    pad2_hit = (h_q >= 10'(PADDLE2_L)) && (h_q <= 10'(PADDLE2_R)) &&
               (v_e >= {1'b0, sp2_q}) && (v_e < {1'b0, sp2_q} + 11'(PADDLE_LEN));
`ifdef PONG_WALL_DRAW_EN
    wall_hit = (h_q < 10'(WALL_W)) || (h_q >= 10'(H_ACTIVE - WALL_W)) ||
               (v_q < 10'(WALL_W)) || (v_q >= 10'(V_ACTIVE - WALL_W));
`endif
    if (!active)                   pix_rgb = 12'h000;
    else if (ball_hit)             pix_rgb = 12'hFFF;
    else if (pad1_hit)             pix_rgb = 12'h00F;
    else if (pad2_hit)             pix_rgb = 12'h0F0;
`ifdef PONG_WALL_DRAW_EN
    else if (wall_hit)             pix_rgb = 12'h888;
`endif
    else if (flash_q != '0)        pix_rgb = 12'h400;
    else                           pix_rgb = 12'h000;
  end

  // Output stage: all pixel outputs describe the pixel just completed
  always_comb begin
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    video_on_d   = video_on_q;
    rgb_d        = rgb_q;
    pixel_x_d    = pixel_x_q;
    pixel_y_d    = pixel_y_q;
    frame_tick_d = frame_evt;
    if (pix_tick) begin
      hsync_d    = !((h_q >= 10'(H_SYNC_S)) && (h_q < 10'(H_SYNC_E)));
      vsync_d    = !((v_q >= 10'(V_SYNC_S)) && (v_q < 10'(V_SYNC_E)));
      video_on_d = active;
      rgb_d      = pix_rgb;
      pixel_x_d  = h_q;
      pixel_y_d  = v_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q        <= '0;
      h_q          <= '0;
      v_q          <= '0;
      sbx_q        <= 10'd319;
      sby_q        <= 10'd239;
      sp1_q        <= 10'd214;
      sp2_q        <= 10'd214;
      flash_q      <= '0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      video_on_q   <= 1'b0;
      rgb_q        <= '0;
      pixel_x_q    <= '0;
      pixel_y_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      h_q          <= h_d;
      v_q          <= v_d;
      sbx_q        <= sbx_d;
      sby_q        <= sby_d;
      sp1_q        <= sp1_d;
      sp2_q        <= sp2_d;
      flash_q      <= flash_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      video_on_q   <= video_on_d;
      rgb_q        <= rgb_d;
      pixel_x_q    <= pixel_x_d;
      pixel_y_q    <= pixel_y_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign red        = rgb_q[11:8];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[3:0];
  assign video_on   = video_on_q;
  assign pixel_x    = pixel_x_q;
  assign pixel_y    = pixel_y_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Bench for pong_vga_renderer on a shrunken raster (40x24 pixels per frame) so many frames fit
// in a short run; a raster-index reference model checks every clk alongside directed checks.
module tb_pong_vga_renderer;

  localparam int CD = 2;
  localparam int HA = 24, HF = 2, HS = 8, HB = 6;
  localparam int VA = 16, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int P1L = 2, P1R = 3, P2L = 20, P2R = 21;
  localparam int PL = 5, BS = 3, FF = 3, WW = 2;
  localparam int FRAME = CD * HT * VT;
`ifdef PONG_WALL_DRAW_EN
  localparam logic [11:0] WALLC = 12'h888;
`else
  localparam logic [11:0] WALLC = 12'h000;
`endif

  logic       clk;
  logic       rst;
  logic [9:0] ball_x, ball_y, paddle1_y, paddle2_y;
  logic       miss1, miss2;
  logic       hsync, vsync, video_on, frame_tick;
  logic [3:0] red, green, blue;
  logic [9:0] pixel_x, pixel_y;

  int tests = 0;
  int fails = 0;
  int sb_prints = 0;

  pong_vga_renderer #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PADDLE1_L(P1L), .PADDLE1_R(P1R), .PADDLE2_L(P2L), .PADDLE2_R(P2R),
    .PADDLE_LEN(PL), .BALL_SIZE(BS),
`ifdef PONG_WALL_DRAW_EN
    .WALL_W(WW),
`endif
    .FLASH_FRAMES(FF)
  ) dut (
    .clk(clk), .rst(rst), .ball_x(ball_x), .ball_y(ball_y),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .miss1(miss1), .miss2(miss2),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the k-th pixel clock edge after reset shows raster pixel k-1.
  int ck;
  int m_nck, m_p, m_x, m_y;
  logic m_pt, m_ft;
  int sh_bx, sh_by, sh_p1, sh_p2, m_fl;
  logic e_hs, e_vs, e_vid, e_ft;
  logic [11:0] e_rgb;
  int e_px, e_py;

  assign m_nck = ck + 1;
  assign m_pt  = (m_nck % CD) == 0;
  assign m_p   = m_nck / CD - 1;
  assign m_x   = m_p % HT;
  assign m_y   = (m_p / HT) % VT;
  assign m_ft  = m_pt && (m_x == HT - 1) && (m_y == VA - 1);

  function automatic logic [11:0] colour(input int x, input int y, input int bx, input int by,
                                         input int p1, input int p2, input int fl);
    if (x >= HA || y >= VA) return 12'h000;
    if (x >= bx && x < bx + BS && y >= by && y < by + BS) return 12'hFFF;
    if (x >= P1L && x <= P1R && y >= p1 && y < p1 + PL) return 12'h00F;
    if (x >= P2L && x <= P2R && y >= p2 && y < p2 + PL) return 12'h0F0;
`ifdef PONG_WALL_DRAW_EN
    if (x < WW || x >= HA - WW || y < WW || y >= VA - WW) return 12'h888;
`endif
    return (fl != 0) ? 12'h400 : 12'h000;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ck <= 0;
      e_hs <= 1'b1; e_vs <= 1'b1; e_vid <= 1'b0; e_ft <= 1'b0;
      e_rgb <= 12'h000; e_px <= 0; e_py <= 0;
      sh_bx <= 319; sh_by <= 239; sh_p1 <= 214; sh_p2 <= 214;
      m_fl <= 0;
    end else begin
      ck   <= ck + 1;
      e_ft <= m_ft;
      if (m_pt) begin
        e_px  <= m_x;
        e_py  <= m_y;
        e_vid <= (m_x < HA) && (m_y < VA);
        e_hs  <= !(m_x >= HA + HF && m_x < HA + HF + HS);
        e_vs  <= !(m_y >= VA + VF && m_y < VA + VF + VS);
        e_rgb <= colour(m_x, m_y, sh_bx, sh_by, sh_p1, sh_p2, m_fl);
      end
      if (m_ft) begin
        sh_bx <= int'(ball_x); sh_by <= int'(ball_y);
        sh_p1 <= int'(paddle1_y); sh_p2 <= int'(paddle2_y);
      end
      if (miss1 || miss2)          m_fl <= FF;
      else if (m_ft && m_fl > 0)   m_fl <= m_fl - 1;
    end
  end

  task automatic sb_loop();
    logic [35:0] act, exp;
    forever begin
      @(negedge clk);
      act = {hsync, vsync, red, green, blue, video_on, pixel_x, pixel_y, frame_tick};
      exp = {e_hs, e_vs, e_rgb, e_vid, 10'(e_px), 10'(e_py), e_ft};
      tests++;
      if (act !== exp) begin
        fails++;
        if (sb_prints < 10) begin
          sb_prints++;
          $display("FAIL scoreboard t=%0t got %h expected %h", $time, act, exp);
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return hsync;
      1:       return vsync;
      default: return frame_tick;
    endcase
  endfunction

  task automatic wait_level(input int sel, input logic val, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge clk); #1;
      n++;
      if (sig(sel) == val) return;
    end
    tests++; fails++;
    $display("FAIL wait_sel%0d: level %0b not seen within %0d clks", sel, val, budget);
    n = -1;
  endtask

  task automatic check_pix(input string name, input int x, input int y, input logic [11:0] exp);
    int n = 0;
    while (n < 2 * FRAME + 8) begin
      @(posedge clk); #1;
      n++;
      if (int'(pixel_x) == x && int'(pixel_y) == y) begin
        chk(name, int'({red, green, blue}), int'(exp));
        return;
      end
    end
    tests++; fails++;
    $display("FAIL %s: pixel (%0d,%0d) not reached, expected %h", name, x, y, exp);
  endtask

  task automatic pulse_miss(input int which, input int len);
    @(negedge clk);
    if (which == 1) miss1 = 1'b1; else miss2 = 1'b1;
    repeat (len) @(negedge clk);
    miss1 = 1'b0; miss2 = 1'b0;
  endtask

  function automatic logic [9:0] rpos();
    if ($urandom_range(0, 9) == 0) return 10'($urandom_range(1015, 1023));
    return 10'($urandom_range(0, HA + 4));
  endfunction

  typedef struct {
    int bx, by, p1, p2, x, y;
    logic [11:0] rgb;
  } vec_t;

  function automatic vec_t mk(input int bx, input int by, input int p1, input int p2,
                              input int x, input int y, input logic [11:0] rgb);
    vec_t v;
    v.bx = bx; v.by = by; v.p1 = p1; v.p2 = p2; v.x = x; v.y = y; v.rgb = rgb;
    return v;
  endfunction

  initial begin
    vec_t tbl[17];
    int n, c0;
    logic newgrp;

    tbl[0]  = mk(5, 6, 4, 10,  2,  3, 12'h000);
    tbl[1]  = mk(5, 6, 4, 10,  2,  4, 12'h00F);
    tbl[2]  = mk(5, 6, 4, 10,  4,  6, 12'h000);
    tbl[3]  = mk(5, 6, 4, 10,  5,  6, 12'hFFF);
    tbl[4]  = mk(5, 6, 4, 10,  8,  6, 12'h000);
    tbl[5]  = mk(5, 6, 4, 10,  3,  8, 12'h00F);
    tbl[6]  = mk(5, 6, 4, 10,  7,  8, 12'hFFF);
    tbl[7]  = mk(5, 6, 4, 10,  3,  9, 12'h000);
    tbl[8]  = mk(5, 6, 4, 10,  5,  9, 12'h000);
    tbl[9]  = mk(5, 6, 4, 10, 20, 10, 12'h0F0);
    tbl[10] = mk(5, 6, 4, 10, 22, 10, WALLC);
    tbl[11] = mk(5, 6, 4, 10, 21, 14, 12'h0F0);
    tbl[12] = mk(5, 6, 4, 10, 21, 15, WALLC);
    tbl[13] = mk(2, 4, 4, 10,  2,  4, 12'hFFF);
    tbl[14] = mk(2, 4, 4, 10,  1, 10, WALLC);
    tbl[15] = mk(1, 10, 4, 10, 1, 10, 12'hFFF);
    tbl[16] = mk(5, 1022, 4, 10, 5, 0, WALLC);

    rst = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
    ball_x = 10'd100; ball_y = 10'd100; paddle1_y = 10'd100; paddle2_y = 10'd100;
    fork sb_loop(); join_none

    repeat (3) @(negedge clk);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_rgb", int'({red, green, blue}), 0);
    chk("rst_video_on", int'(video_on), 0);
    chk("rst_pixel_xy", int'({pixel_x, pixel_y}), 0);
    chk("rst_frame_tick", int'(frame_tick), 0);

    @(negedge clk); rst = 1'b1;
    wait_level(0, 1'b0, 4 * CD * HT, n);
    chk("hsync_first_low_clk", n, CD * (HA + HF + 1));
    wait_level(0, 1'b1, 4 * CD * HT, n);
    chk("hsync_low_clks", n, CD * HS);
    wait_level(2, 1'b1, 2 * FRAME, n);
    chk("first_ftick_clk", ck, CD * HT * VA);
    c0 = ck;
    wait_level(1, 1'b0, FRAME, n);
    chk("vsync_low_line", int'(pixel_y), VA + VF);
    chk("vsync_low_x", int'(pixel_x), 0);
    wait_level(1, 1'b1, FRAME, n);
    chk("vsync_low_clks", n, CD * HT * VS);
    wait_level(2, 1'b1, 2 * FRAME, n);
    chk("ftick_period", ck - c0, FRAME);

    for (int i = 0; i < 17; i++) begin
      newgrp = (i == 0);
      if (i > 0)
        newgrp = (tbl[i].bx != tbl[i-1].bx) || (tbl[i].by != tbl[i-1].by) ||
                 (tbl[i].p1 != tbl[i-1].p1) || (tbl[i].p2 != tbl[i-1].p2);
      if (newgrp) begin
        @(negedge clk);
        ball_x = 10'(tbl[i].bx); ball_y = 10'(tbl[i].by);
        paddle1_y = 10'(tbl[i].p1); paddle2_y = 10'(tbl[i].p2);
        wait_level(2, 1'b1, 2 * FRAME, n);
      end
      check_pix($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].rgb);
    end

    // A mid-frame position change only shows from the next frame on
    @(negedge clk); ball_x = 10'd5; ball_y = 10'd6;
    wait_level(2, 1'b1, 2 * FRAME, n);
    check_pix("midframe_pre", 0, 2, 12'h000);
    @(negedge clk); ball_x = 10'd12;
    check_pix("midframe_old_pos", 5, 6, 12'hFFF);
    check_pix("midframe_new_pos_hidden", 12, 6, 12'h000);
    check_pix("nextframe_old_pos", 5, 6, 12'h000);
    check_pix("nextframe_new_pos", 12, 6, 12'hFFF);

    // Miss flash: red background for FF frame ticks, restarted by a later miss
    @(negedge clk); ball_x = 10'd100; ball_y = 10'd100;
    wait_level(2, 1'b1, 2 * FRAME, n);
    pulse_miss(1, 3);
    for (int k = 0; k <= FF; k++) begin
      check_pix($sformatf("flash_k%0d", k), 12, 12, (k < FF) ? 12'h400 : 12'h000);
      if (k < FF) wait_level(2, 1'b1, 2 * FRAME, n);
    end
    wait_level(2, 1'b1, 2 * FRAME, n);
    pulse_miss(1, 3);
    for (int k = 0; k < 2; k++) begin
      check_pix($sformatf("flash2_k%0d", k), 12, 12, 12'h400);
      wait_level(2, 1'b1, 2 * FRAME, n);
    end
    pulse_miss(2, 1);
    for (int k = 0; k <= FF; k++) begin
      check_pix($sformatf("flash_restart_k%0d", k), 12, 12, (k < FF) ? 12'h400 : 12'h000);
      if (k < FF) wait_level(2, 1'b1, 2 * FRAME, n);
    end

    // Random positions and misses at arbitrary times; the model checks every clk
    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(10, 150)) @(negedge clk);
      case ($urandom_range(0, 4))
        0: ball_x = rpos();
        1: ball_y = rpos();
        2: paddle1_y = rpos();
        3: paddle2_y = rpos();
        default: pulse_miss($urandom_range(1, 2), $urandom_range(1, 3));
      endcase
    end

    // Asynchronous reset in mid-frame
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("midrst_hsync", int'(hsync), 1);
    chk("midrst_rgb", int'({red, green, blue}), 0);
    chk("midrst_pixel_xy", int'({pixel_x, pixel_y}), 0);
    chk("midrst_video_on", int'(video_on), 0);
    @(posedge clk); #2 rst = 1'b1;
    wait_level(2, 1'b1, 2 * FRAME, n);
    chk("midrst_first_ftick_clk", ck, CD * HT * VA);
    check_pix("midrst_flash_cleared", 12, 12, 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
